// File: rtl/image_scaler_gen_if.sv
// Output tuple stream of the image scaler: one (source, destination) pixel pair
// per transfer on a valid/ready handshake.
`timescale 1ns/1ps
interface image_scaler_gen_if #(
  parameter int DIM_W  = 10,
  parameter int ADDR_W = 19
);
  logic              out_valid;
  logic              out_ready;
  logic [ADDR_W-1:0] src_addr;
  logic [ADDR_W-1:0] dst_addr;
  logic [DIM_W-1:0]  src_x;
  logic [DIM_W-1:0]  src_y;

  modport master (output out_valid, src_addr, dst_addr, src_x, src_y, input out_ready);
  modport slave  (input out_valid, src_addr, dst_addr, src_x, src_y, output out_ready);
endinterface

// File: rtl/image_scaler_gen.sv
// Nearest-neighbour down-scaler address generator: walks the destination grid with
// fixed-point accumulators and streams clamped source/destination addresses under credit control.
`timescale 1ns/1ps
module image_scaler_gen #(
  parameter int SRC_W  = 640,
  parameter int SRC_H  = 480,
  parameter int DIM_W  = 10,
  parameter int ADDR_W = 19,
  parameter int FRAC   = 4,
  parameter int STEP_W = 13
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic [STEP_W-1:0]   step,
  input  logic [DIM_W-1:0]    dst_w,
  input  logic [DIM_W-1:0]    dst_h,
  input  logic [ADDR_W-1:0]   credit_limit,
  input  logic                credit_free,
  image_scaler_gen_if.master  stream,
  output logic                busy,
  output logic                done
);
  localparam int ACC_W = DIM_W + STEP_W;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t              state;
  logic [STEP_W-1:0]   step_r;
  logic [DIM_W-1:0]    dst_w_r, dst_h_r;
  logic [ADDR_W-1:0]   limit_r;
  logic [DIM_W-1:0]    dx, dy;
  logic [ACC_W-1:0]    ax, ay;
  logic [ADDR_W-1:0]   outstanding;
  logic [ADDR_W-1:0]   src_addr_r, dst_addr_r;
  logic [DIM_W-1:0]    src_x_r, src_y_r;

  logic                xfer, row_end, last_px, credit_ok, free_ok;
  logic [ACC_W-1:0]    ax_next, ay_next;
  logic [DIM_W-1:0]    sx_next, sy_next;
  logic [ADDR_W-1:0]   sa_next;

  // Round half up on the fractional accumulator, then clamp into the source image.
  function automatic logic [DIM_W-1:0] to_coord(input logic [ACC_W-1:0] acc,
                                                input int unsigned lim);
    logic [ACC_W-1:0] rounded;
    rounded = (acc >> FRAC) + {{(ACC_W-1){1'b0}}, acc[FRAC-1]};
    if (rounded > ACC_W'(lim - 1)) to_coord = DIM_W'(lim - 1);
    else                           to_coord = rounded[DIM_W-1:0];
  endfunction

  assign xfer      = stream.out_valid && stream.out_ready;
  assign row_end   = (dx == dst_w_r - DIM_W'(1));
  assign last_px   = row_end && (dy == dst_h_r - DIM_W'(1));
  assign credit_ok = (limit_r == '0) || (outstanding < limit_r);
  assign free_ok   = credit_free && (outstanding != '0);

  assign stream.out_valid = (state == S_RUN) && credit_ok;
  assign stream.src_addr  = src_addr_r;
  assign stream.dst_addr  = dst_addr_r;
  assign stream.src_x     = src_x_r;
  assign stream.src_y     = src_y_r;

  always_comb begin
    ax_next = row_end ? '0 : ax + ACC_W'(step_r);
    ay_next = row_end ? ay + ACC_W'(step_r) : ay;
    sx_next = to_coord(ax_next, SRC_W);
    sy_next = to_coord(ay_next, SRC_H);
    sa_next = ADDR_W'(sy_next) * ADDR_W'(SRC_W) + ADDR_W'(sx_next);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= S_IDLE;
      step_r      <= '0;
      dst_w_r     <= '0;
      dst_h_r     <= '0;
      limit_r     <= '0;
      dx          <= '0;
      dy          <= '0;
      ax          <= '0;
      ay          <= '0;
      outstanding <= '0;
      src_addr_r  <= '0;
      dst_addr_r  <= '0;
      src_x_r     <= '0;
      src_y_r     <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
    end else begin
      // A release coincident with a transfer cancels out; releases at zero are dropped.
      if (xfer && !free_ok)      outstanding <= outstanding + ADDR_W'(1);
      else if (!xfer && free_ok) outstanding <= outstanding - ADDR_W'(1);

      done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            step_r     <= step;
            dst_w_r    <= dst_w;
            dst_h_r    <= dst_h;
            limit_r    <= credit_limit;
            dx         <= '0;
            dy         <= '0;
            ax         <= '0;
            ay         <= '0;
            src_addr_r <= '0;
            dst_addr_r <= '0;
            src_x_r    <= '0;
            src_y_r    <= '0;
            if (dst_w == '0 || dst_h == '0) begin
              state <= S_DONE;
              done  <= 1'b1;
            end else begin
              state <= S_RUN;
              busy  <= 1'b1;
            end
          end
        end
        S_RUN: begin
          if (xfer) begin
            if (last_px) begin
              state <= S_DONE;
              busy  <= 1'b0;
              done  <= 1'b1;
            end else begin
              dx         <= row_end ? '0 : dx + DIM_W'(1);
              dy         <= row_end ? dy + DIM_W'(1) : dy;
              ax         <= ax_next;
              ay         <= ay_next;
              dst_addr_r <= dst_addr_r + ADDR_W'(1);
              src_x_r    <= sx_next;
              src_y_r    <= sy_next;
              src_addr_r <= sa_next;
            end
          end
        end
        S_DONE:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_image_scaler_gen.sv
// Scoreboard bench for image_scaler_gen: directed rounds push expected tuples,
// a negedge monitor pops and compares them as the DUT presents each tuple.
`timescale 1ns/1ps
module tb_image_scaler_gen;
  localparam int SRC_W  = 640;
  localparam int SRC_H  = 480;
  localparam int DIM_W  = 10;
  localparam int ADDR_W = 19;
  localparam int FRAC   = 4;
  localparam int STEP_W = 13;

  typedef struct packed {
    logic [ADDR_W-1:0] sa;
    logic [ADDR_W-1:0] da;
    logic [DIM_W-1:0]  sx;
    logic [DIM_W-1:0]  sy;
  } tuple_t;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              start = 1'b0;
  logic [STEP_W-1:0] step = '0;
  logic [DIM_W-1:0]  dst_w = '0;
  logic [DIM_W-1:0]  dst_h = '0;
  logic [ADDR_W-1:0] credit_limit = '0;
  logic              credit_free = 1'b0;
  logic              busy, done;

  tuple_t exp_q[$];
  tuple_t mon_e;
  string  pfx;
  int     checks_total = 0;
  int     checks_passed = 0;
  int     xfer_count = 0;
  int     done_count = 0;
  int     base, d0;

  image_scaler_gen_if #(.DIM_W(DIM_W), .ADDR_W(ADDR_W)) bus ();

  image_scaler_gen #(
    .SRC_W(SRC_W), .SRC_H(SRC_H), .DIM_W(DIM_W), .ADDR_W(ADDR_W), .FRAC(FRAC), .STEP_W(STEP_W)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .start(start),
    .step(step),
    .dst_w(dst_w),
    .dst_h(dst_h),
    .credit_limit(credit_limit),
    .credit_free(credit_free),
    .stream(bus),
    .busy(busy),
    .done(done)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks_total++;
    if (actual === expected) checks_passed++;
    else $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pushExp(input int sa, input int da, input int sx, input int sy);
    tuple_t t;
    t.sa = ADDR_W'(sa);
    t.da = ADDR_W'(da);
    t.sx = DIM_W'(sx);
    t.sy = DIM_W'(sy);
    exp_q.push_back(t);
  endtask

  // Unit-step grid: destination pixel (x,y) reads source pixel (x,y).
  task automatic pushGrid(input int w, input int h);
    for (int y = 0; y < h; y++)
      for (int x = 0; x < w; x++)
        pushExp(y * SRC_W + x, y * w + x, x, y);
  endtask

  task automatic applyStimulus(input int s, input int w, input int h, input int lim);
    step         = STEP_W'(s);
    dst_w        = DIM_W'(w);
    dst_h        = DIM_W'(h);
    credit_limit = ADDR_W'(lim);
    start        = 1'b1;
    tick();
    start        = 1'b0;
  endtask

  task automatic waitXfers(input int target, input string name);
    int n;
    n = 0;
    while (xfer_count < target && n < 300) begin
      tick();
      n++;
    end
    checkOutput(name, xfer_count, target);
  endtask

  task automatic checkRoundEnd(input string name);
    checkOutput({name, "_done"}, done, 1);
    checkOutput({name, "_busy_low"}, busy, 0);
    checkOutput({name, "_valid_low"}, bus.out_valid, 0);
    tick();
    checkOutput({name, "_done_clear"}, done, 0);
    checkOutput({name, "_done_pulses"}, done_count - d0, 1);
    checkOutput({name, "_queue_empty"}, exp_q.size(), 0);
  endtask

  task automatic checkZeroOutputs(input string name);
    checkOutput({name, "_valid"}, bus.out_valid, 0);
    checkOutput({name, "_busy"}, busy, 0);
    checkOutput({name, "_done"}, done, 0);
    checkOutput({name, "_src_addr"}, bus.src_addr, 0);
    checkOutput({name, "_dst_addr"}, bus.dst_addr, 0);
    checkOutput({name, "_src_x"}, bus.src_x, 0);
    checkOutput({name, "_src_y"}, bus.src_y, 0);
  endtask

  // While the DUT holds a tuple it must match the head of the queue; it is popped on transfer.
  always @(negedge clk) begin
    if (rst_n) begin
      if (done) done_count++;
      if (bus.out_valid) begin
        if (exp_q.size() == 0) begin
          checkOutput("unexpected_tuple_dst_addr", bus.dst_addr, 32'hFFFF_FFFF);
        end else begin
          mon_e = exp_q[0];
          pfx = bus.out_ready ? "xfer" : "stall";
          checkOutput({pfx, "_src_addr"}, bus.src_addr, mon_e.sa);
          checkOutput({pfx, "_dst_addr"}, bus.dst_addr, mon_e.da);
          checkOutput({pfx, "_src_x"}, bus.src_x, mon_e.sx);
          checkOutput({pfx, "_src_y"}, bus.src_y, mon_e.sy);
          if (bus.out_ready) void'(exp_q.pop_front());
        end
        if (bus.out_ready) xfer_count++;
      end
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    bus.out_ready = 1'b1;
    #12;
    checkZeroOutputs("reset");
    tick();
    rst_n = 1'b1;
    tick();

    $display("[TB] unit scale 4x3");
    pushGrid(4, 3);
    base = xfer_count; d0 = done_count;
    applyStimulus(16, 4, 3, 0);
    checkOutput("latency_valid", bus.out_valid, 1);
    checkOutput("latency_busy", busy, 1);
    waitXfers(base + 12, "unit_xfers");
    checkRoundEnd("unit");

    $display("[TB] fractional step 23, 5x2");
    pushExp(0, 0, 0, 0);   pushExp(1, 1, 1, 0);   pushExp(3, 2, 3, 0);
    pushExp(4, 3, 4, 0);   pushExp(6, 4, 6, 0);
    pushExp(640, 5, 0, 1); pushExp(641, 6, 1, 1); pushExp(643, 7, 3, 1);
    pushExp(644, 8, 4, 1); pushExp(646, 9, 6, 1);
    base = xfer_count; d0 = done_count;
    applyStimulus(23, 5, 2, 0);
    waitXfers(base + 10, "frac_xfers");
    checkRoundEnd("frac");

    $display("[TB] backpressure");
    pushGrid(4, 3);
    base = xfer_count; d0 = done_count;
    applyStimulus(16, 4, 3, 0);
    waitXfers(base + 2, "bp_first_two");
    bus.out_ready = 1'b0;
    repeat (3) tick();
    checkOutput("bp_stall_count", xfer_count - base, 2);
    checkOutput("bp_stall_valid", bus.out_valid, 1);
    bus.out_ready = 1'b1;
    waitXfers(base + 12, "bp_xfers");
    checkRoundEnd("bp");

    $display("[TB] clamp step 8191, 3x2");
    pushExp(0, 0, 0, 0);        pushExp(512, 1, 512, 0);    pushExp(639, 2, 639, 0);
    pushExp(306560, 3, 0, 479); pushExp(307072, 4, 512, 479); pushExp(307199, 5, 639, 479);
    base = xfer_count; d0 = done_count;
    applyStimulus(8191, 3, 2, 0);
    waitXfers(base + 6, "clamp_xfers");
    checkRoundEnd("clamp");

    $display("[TB] zero-size round");
    base = xfer_count; d0 = done_count;
    applyStimulus(16, 4, 0, 0);
    checkOutput("zero_done", done, 1);
    checkOutput("zero_valid", bus.out_valid, 0);
    checkOutput("zero_busy", busy, 0);
    tick();
    checkOutput("zero_done_clear", done, 0);
    repeat (3) tick();
    checkOutput("zero_no_xfer", xfer_count - base, 0);
    checkOutput("zero_done_pulses", done_count - d0, 1);

    $display("[TB] start during run");
    pushExp(0, 0, 0, 0); pushExp(1, 1, 1, 0); pushExp(2, 2, 2, 0);
    base = xfer_count; d0 = done_count;
    applyStimulus(16, 3, 1, 0);
    waitXfers(base + 1, "restart_first");
    step = 13'd32; dst_w = 10'd7; dst_h = 10'd5;
    start = 1'b1;
    tick();
    start = 1'b0;
    waitXfers(base + 3, "restart_xfers");
    checkRoundEnd("restart");
    repeat (3) tick();
    checkOutput("restart_no_new_round", xfer_count - base, 3);
    checkOutput("restart_idle_valid", bus.out_valid, 0);

    $display("[TB] reset mid-round");
    pushGrid(4, 3);
    base = xfer_count; d0 = done_count;
    applyStimulus(16, 4, 3, 0);
    waitXfers(base + 5, "abort_first_five");
    rst_n = 1'b0;
    #1;
    checkZeroOutputs("abort");
    exp_q.delete();
    repeat (3) tick();
    rst_n = 1'b1;
    tick();
    checkOutput("abort_no_done", done_count - d0, 0);
    pushGrid(4, 3);
    base = xfer_count;
    applyStimulus(16, 4, 3, 0);
    waitXfers(base + 12, "abort_restart_xfers");
    checkRoundEnd("abort_restart");

    $display("[TB] credits");
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
    pushGrid(4, 3);
    base = xfer_count; d0 = done_count;
    applyStimulus(16, 4, 3, 2);
    repeat (8) tick();
    checkOutput("credit_limit_xfers", xfer_count - base, 2);
    checkOutput("credit_limit_valid", bus.out_valid, 0);
    credit_free = 1'b1;
    tick();
    credit_free = 1'b0;
    checkOutput("credit_free_valid", bus.out_valid, 1);
    repeat (3) tick();
    checkOutput("credit_one_more", xfer_count - base, 3);
    checkOutput("credit_relimit_valid", bus.out_valid, 0);
    credit_free = 1'b1;
    tick();
    tick();
    credit_free = 1'b0;
    checkOutput("credit_coincident_valid", bus.out_valid, 1);
    repeat (3) tick();
    checkOutput("credit_coincident_xfers", xfer_count - base, 5);
    checkOutput("credit_coincident_limit", bus.out_valid, 0);
    credit_free = 1'b1;
    waitXfers(base + 12, "credit_xfers");
    credit_free = 1'b0;
    checkRoundEnd("credit");

    $display("%0d/%0d checks passed", checks_passed, checks_total);
    $finish;
  end
endmodule
